fpalu_result_collector: RTL and testbench
=========================================

# fpalu_result_collector

Result-side companion to the floating-point ALU (`aluunit`): samples the ALU's IEEE-754 single-precision result `z` and compare flags whenever the issuing side marks a cycle as valid. Each sampled result is classified (zero, subnormal, normal, infinity, quiet/signalling NaN) and buffered with its opcode in a small FWFT FIFO. Downstream logic drains the FIFO with a valid/ready handshake. The block sits between `aluunit` outputs and the result consumer (checker, UART framer or register file).

## Interface
- `DEPTH`, 4: FIFO entries; power of two, minimum 2.
- `OP_W`, 3: opcode width; matches the ALU `op` port.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: reset, asynchronous, active-low.
- `in_valid` input 1: the `in_*` bus holds a finished ALU result this cycle.
- `in_op` input OP_W: opcode that produced the result.
- `in_z` input 32: ALU result `z`.
- `in_gr`, `in_ls`, `in_eq` input 1 each: ALU compare flags.
- `out_valid` output 1: the FIFO head is valid.
- `out_ready` input 1: consumer accepts the head.
- `out_op` output OP_W: head opcode.
- `out_z` output 32: head result.
- `out_flags` output 3: head `{gr,ls,eq}`.
- `out_class` output 3: head class code.
- `count` output $clog2(DEPTH)+1: occupancy.
- `overflow` output 1: sticky flag set when a result is dropped.
- `clr_ovf` input 1: synchronous clear of `overflow`.
- `nan_cnt` output 16: count of NaN results captured (see Configuration).

## Operation
- Capture condition: `in_valid` and `in_op != 3'b110` (110 is the ALU idle opcode and is never captured).
- Class codes, computed from `in_z` at capture time and stored with the entry:
  - 000: normal.
  - 001: zero (exp=0, frac=0, either sign).
  - 010: subnormal (exp=0, frac≠0).
  - 011: infinity (exp=0xFF, frac=0).
  - 100: qNaN (exp=0xFF, frac[22]=1).
  - 101: sNaN (exp=0xFF, frac[22]=0, frac≠0).
- FIFO behaviour:
  - First-word-fall-through: `out_valid = (count != 0)`, and the `out_*` fields show the head entry.
  - Pop occurs when `out_valid && out_ready`.
  - Push occurs on capture when not full, or when full and a pop happens in the same cycle.
- Capture when full with no pop: the entry is dropped, `count` is unchanged, and `overflow` is set to 1.
- Pop when empty: ignored, with no pointer movement.
- Simultaneous push and pop: `count` is unchanged and both pointers advance. This is legal at full and at non-empty. When empty, a push with `out_ready` high does not bypass: the entry appears on the next cycle.
- Pointers wrap modulo DEPTH. Occupancy is tracked by `count`, not by comparing pointers.
- `overflow`: a drop in the same cycle as `clr_ovf` leaves it set, because set wins over clear.
- Reset values: `count`=0, `out_valid`=0, `overflow`=0, `nan_cnt`=0, and both pointers 0. RAM contents are not reset, so `out_z`/`out_op`/`out_flags`/`out_class` are don't-care while `out_valid`=0.
- Reset asserted mid-stream: all buffered entries are discarded immediately (asynchronously). The first capture after deassertion lands at entry 0.

## Timing
- Capture to head: a result pushed at edge N into an empty FIFO gives `out_valid`=1 with its fields after edge N (1-cycle latency).
- Handshake: `out_*` hold stable while `out_valid && !out_ready`. The next entry is presented the cycle after the pop edge.
- `count`, `overflow` and `nan_cnt` are registered and update at the same edge as the push/pop they reflect.
- Steady-state throughput: one capture and one pop per cycle.

## Configuration
- Macro `FPRC_NAN_STATS_EN`.
- Defined: `nan_cnt` increments on every captured entry with class 100 or 101. It saturates at 0xFFFF. Dropped (overflow) entries are also counted. `clr_ovf` clears it as well.
- Undefined: `nan_cnt` is tied to 0 and no counter logic is built.

## Test plan
- **Add then drain:**
  - Stimulus: `in_op`=000, `in_z`=0x3E800000 (0.25 = 1.0 + −0.75), `in_valid` for 1 cycle, `out_ready`=1.
  - Required: next cycle `out_valid`=1, `out_z`=0x3E800000, `out_class`=000, `count`=1; the following cycle `count`=0.
- **Idle filter:**
  - Stimulus: `in_valid`=1 with `in_op`=110 for 5 cycles.
  - Required: `count` stays 0 and `out_valid` stays 0.
- **Classification:**
  - Stimulus: push 0x80000000, 0x00000001, 0x7F800000, 0x7FC00000, 0x7F800001, 0xC1A00000 (−20.0, mul).
  - Required: `out_class` sequence 001, 010, 011, 100, 101, 000.
  - With `FPRC_NAN_STATS_EN`: `nan_cnt`=2.
- **Full/overflow:**
  - Stimulus: `out_ready`=0, push 5 results with DEPTH=4.
  - Required: `count`=4 and `overflow`=1. Drained order contains the first four only.
  - Stimulus: `clr_ovf` pulse.
  - Required: `overflow`=0.
- **Full with simultaneous push/pop:**
  - Stimulus: at `count`=4, `out_ready`=1 and push 0xBE800000 in the same cycle.
  - Required: `count` stays 4, `overflow` stays 0, and 0xBE800000 emerges as the 4th pop after it.
- **Async reset mid-stream:**
  - Stimulus: with `count`=3, drop `rst_n` between edges.
  - Required: `out_valid` and `count` go to 0 immediately. After release, a push of 0x3F800000 appears as the head one cycle later.

Source files
------------

// File: rtl/fpalu_result_collector.sv
// Classifies and buffers aluunit results in a first-word-fall-through FIFO drained by valid/ready.
// Optional macro FPRC_NAN_STATS_EN builds the saturating NaN capture counter behind nan_cnt.
module fpalu_result_collector #(
    parameter int DEPTH = 4,
    parameter int OP_W  = 3
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid,
    input  logic [OP_W-1:0]          in_op,
    input  logic [31:0]              in_z,
    input  logic                     in_gr,
    input  logic                     in_ls,
    input  logic                     in_eq,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [OP_W-1:0]          out_op,
    output logic [31:0]              out_z,
    output logic [2:0]               out_flags,
    output logic [2:0]               out_class,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    input  logic                     clr_ovf,
    output logic [15:0]              nan_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [OP_W-1:0] IDLE_OP = OP_W'(3'b110);

    logic [31:0]     mem_z     [DEPTH];
    logic [OP_W-1:0] mem_op    [DEPTH];
    logic [2:0]      mem_flags [DEPTH];
    logic [2:0]      mem_class [DEPTH];

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    logic       capture;
    logic       full;
    logic       pop;
    logic       push;
    logic       drop;
    logic [2:0] in_class;
    logic       in_is_nan;

    logic [7:0]  exp_f;
    logic [22:0] frac_f;

    assign exp_f  = in_z[30:23];
    assign frac_f = in_z[22:0];

    always_comb begin
        in_class = 3'b000;
        if (exp_f == 8'h00) begin
            in_class = (frac_f == '0) ? 3'b001 : 3'b010;
        end else if (exp_f == 8'hFF) begin
            if (frac_f == '0)
                in_class = 3'b011;
            else if (frac_f[22])
                in_class = 3'b100;
            else
                in_class = 3'b101;
        end
    end

    assign in_is_nan = (in_class == 3'b100) || (in_class == 3'b101);

    assign capture   = in_valid && (in_op != IDLE_OP);
    assign out_valid = (count != '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign pop       = out_valid && out_ready;
    // Push at full is only legal when the head leaves in the same cycle.
    assign push      = capture && (!full || pop);
    assign drop      = capture && full && !pop;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_z[wr_ptr]     <= in_z;
            mem_op[wr_ptr]    <= in_op;
            mem_flags[wr_ptr] <= {in_gr, in_ls, in_eq};
            mem_class[wr_ptr] <= in_class;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + AW'(1);
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (drop)
                overflow <= 1'b1;
            else if (clr_ovf)
                overflow <= 1'b0;
        end
    end

    assign out_z     = mem_z[rd_ptr];
    assign out_op    = mem_op[rd_ptr];
    assign out_flags = mem_flags[rd_ptr];
    assign out_class = mem_class[rd_ptr];

`ifdef FPRC_NAN_STATS_EN
    logic [15:0] nan_q;

    // Dropped NaNs still count; a clear restarts from this cycle's capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            nan_q <= '0;
        end else if (clr_ovf) begin
            nan_q <= (capture && in_is_nan) ? 16'd1 : 16'd0;
        end else if (capture && in_is_nan && (nan_q != '1)) begin
            nan_q <= nan_q + 16'd1;
        end
    end

    assign nan_cnt = nan_q;
`else
    logic unused_nan;
    assign unused_nan = in_is_nan;
    assign nan_cnt    = '0;
`endif

endmodule

// File: tb/tb_fpalu_result_collector.sv
// Directed self-checking bench for fpalu_result_collector (DEPTH=4, OP_W=3).
module tb_fpalu_result_collector;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [2:0]  in_op;
    logic [31:0] in_z;
    logic        in_gr;
    logic        in_ls;
    logic        in_eq;
    logic        out_valid;
    logic        out_ready;
    logic [2:0]  out_op;
    logic [31:0] out_z;
    logic [2:0]  out_flags;
    logic [2:0]  out_class;
    logic [2:0]  count;
    logic        overflow;
    logic        clr_ovf;
    logic [15:0] nan_cnt;

    int checks = 0;
    int errors = 0;

    fpalu_result_collector #(.DEPTH(4), .OP_W(3)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_op     (in_op),
        .in_z      (in_z),
        .in_gr     (in_gr),
        .in_ls     (in_ls),
        .in_eq     (in_eq),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_op    (out_op),
        .out_z     (out_z),
        .out_flags (out_flags),
        .out_class (out_class),
        .count     (count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf),
        .nan_cnt   (nan_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] cls_z   [6];
    logic [2:0]  cls_exp [6];
    logic [15:0] exp_nan;

    initial begin
        cls_z[0] = 32'h80000000; cls_exp[0] = 3'b001;
        cls_z[1] = 32'h00000001; cls_exp[1] = 3'b010;
        cls_z[2] = 32'h7F800000; cls_exp[2] = 3'b011;
        cls_z[3] = 32'h7FC00000; cls_exp[3] = 3'b100;
        cls_z[4] = 32'h7F800001; cls_exp[4] = 3'b101;
        cls_z[5] = 32'hC1A00000; cls_exp[5] = 3'b000;

        rst_n = 1'b0; in_valid = 1'b0; in_op = 3'b000; in_z = '0;
        in_gr = 1'b0; in_ls = 1'b0; in_eq = 1'b0;
        out_ready = 1'b0; clr_ovf = 1'b0;
        #12;
        check("rst_count", 32'(count), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_nan", 32'(nan_cnt), 32'd0);
        rst_n = 1'b1;
        tick();

        // Pop while empty is ignored.
        out_ready = 1'b1;
        tick();
        check("empty_pop_count", 32'(count), 32'd0);

        // Add then drain.
        in_valid = 1'b1; in_op = 3'b000; in_z = 32'h3E800000; in_ls = 1'b1;
        tick();
        in_valid = 1'b0; in_ls = 1'b0;
        check("add_valid", 32'(out_valid), 32'd1);
        check("add_z", out_z, 32'h3E800000);
        check("add_class", 32'(out_class), 32'd0);
        check("add_flags", 32'(out_flags), 32'b010);
        check("add_count", 32'(count), 32'd1);
        tick();
        check("drain_count", 32'(count), 32'd0);
        check("drain_valid", 32'(out_valid), 32'd0);

        // Idle opcode is never captured.
        in_valid = 1'b1; in_op = 3'b110; in_z = 32'h3F800000;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("idle_count", 32'(count), 32'd0);
            check("idle_valid", 32'(out_valid), 32'd0);
        end

        // Classification streamed at one push and one pop per cycle.
        in_op = 3'b010;
        for (int i = 0; i < 6; i++) begin
            in_z = cls_z[i];
            tick();
            check("cls_class", 32'(out_class), 32'(cls_exp[i]));
            check("cls_z", out_z, cls_z[i]);
            check("cls_count", 32'(count), 32'd1);
        end
        in_valid = 1'b0;
`ifdef FPRC_NAN_STATS_EN
        exp_nan = 16'd2;
`else
        exp_nan = 16'd0;
`endif
        check("cls_nan", 32'(nan_cnt), 32'(exp_nan));
        tick();
        check("cls_empty", 32'(count), 32'd0);

        // Fill to full, fifth capture dropped.
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_op = 3'(i);
            in_z = 32'h40000000 + 32'(i);
            tick();
        end
        in_valid = 1'b0;
        check("full_count", 32'(count), 32'd4);
        check("full_ovf", 32'(overflow), 32'd1);
        check("full_head", out_z, 32'h40000000);
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        check("clr_ovf", 32'(overflow), 32'd0);
        check("stall_head", out_z, 32'h40000000);
        check("stall_op", 32'(out_op), 32'd0);
        check("stall_count", 32'(count), 32'd4);

        // Push and pop together at full.
        in_valid = 1'b1; in_op = 3'b001; in_z = 32'hBE800000; out_ready = 1'b1;
        tick();
        in_valid = 1'b0;
        check("pp_count", 32'(count), 32'd4);
        check("pp_ovf", 32'(overflow), 32'd0);
        check("pp_head1", out_z, 32'h40000001);
        tick();
        check("pp_head2", out_z, 32'h40000002);
        tick();
        check("pp_head3", out_z, 32'h40000003);
        tick();
        check("pp_head4", out_z, 32'hBE800000);
        check("pp_class4", 32'(out_class), 32'd0);
        check("pp_count4", 32'(count), 32'd1);
        tick();
        check("pp_empty", 32'(out_valid), 32'd0);

        // Drop in the same cycle as clr_ovf: set wins.
        out_ready = 1'b0;
        in_valid = 1'b1; in_op = 3'b011; in_z = 32'h41000000;
        for (int i = 0; i < 4; i++) tick();
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        in_valid = 1'b0;
        check("setwins_ovf", 32'(overflow), 32'd1);
        check("setwins_nan", 32'(nan_cnt), 32'd0);

        // Async reset mid-stream with three entries held.
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("pre_rst_count", 32'(count), 32'd3);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_valid", 32'(out_valid), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_ovf", 32'(overflow), 32'd0);
        #1;
        rst_n = 1'b1;
        in_valid = 1'b1; in_op = 3'b000; in_z = 32'h3F800000;
        tick();
        in_valid = 1'b0;
        check("post_rst_valid", 32'(out_valid), 32'd1);
        check("post_rst_head", out_z, 32'h3F800000);
        check("post_rst_count", 32'(count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
